// File: rtl/timer_counter_unit_pkg.sv
// Shared definitions for the 8051 timer/counter unit: TMOD field
// positions, mode encodings and SFR operation-bus write masks.
package timer_counter_unit_pkg;

    // Width of the SFR operation bus
    localparam int SFR_OP_LEN = 8;

    // Bit positions inside the 4-bit TMOD nibble of one timer
    localparam int TMOD_GATE = 3;
    localparam int TMOD_CT   = 2;
    localparam int TMOD_M1   = 1;
    localparam int TMOD_M0   = 0;

    // Operating modes selected by {M1, M0}
    typedef enum logic [1:0] {
        MODE_13B   = 2'b00,
        MODE_16B   = 2'b01,
        MODE_AR8   = 2'b10,
        MODE_SPLIT = 2'b11
    } tmr_mode_e;

    // One-hot SFR write operations on the operation bus
    localparam logic [SFR_OP_LEN-1:0] OP_TL0_WR_BYTE = 8'b0000_0001;
    localparam logic [SFR_OP_LEN-1:0] OP_TH0_WR_BYTE = 8'b0000_0010;
    localparam logic [SFR_OP_LEN-1:0] OP_TL1_WR_BYTE = 8'b0000_0100;
    localparam logic [SFR_OP_LEN-1:0] OP_TH1_WR_BYTE = 8'b0000_1000;

endpackage

// File: rtl/timer_counter_unit_pin_sync.sv
// Pin front end: 2-FF synchronisers for the Tx counter pin and the INTx
// gate pin, plus a machine-cycle-sampled falling-edge detector on Tx.
module timer_pin_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_tick,
    input  logic i_t_pin,
    input  logic i_int_n,
    output logic o_t_fall,
    output logic o_int_sync
);

    logic r_t_meta;
    logic r_t_sync;
    logic r_t_samp;
    logic r_int_meta;
    logic r_int_sync;

    // Two-stage synchronisers for both asynchronous pins
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_t_meta   <= 1'b0;
            r_t_sync   <= 1'b0;
            r_int_meta <= 1'b0;
            r_int_sync <= 1'b0;
        end else begin
            r_t_meta   <= i_t_pin;
            r_t_sync   <= r_t_meta;
            r_int_meta <= i_int_n;
            r_int_sync <= r_int_meta;
        end
    end

    // Remember the Tx level seen at the previous machine-cycle tick
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_t_samp <= 1'b0;
        end else if (i_tick) begin
            r_t_samp <= r_t_sync;
        end
    end

    // A falling edge is a 1 at the previous tick followed by a 0 at this tick
    assign o_t_fall   = i_tick & r_t_samp & ~r_t_sync;
    assign o_int_sync = r_int_sync;

endmodule

// File: rtl/timer_counter_unit.sv
// One 8051 timer/counter (T0 or T1): modes 0-3, gating, counter input,
// SFR byte writes and registered overflow pulses toward TCON.
module timer_counter_unit
    import timer_counter_unit_pkg::*;
#(
    parameter bit                    IS_T0    = 1'b1,
    parameter logic [SFR_OP_LEN-1:0] OP_TL_WR = OP_TL0_WR_BYTE,
    parameter logic [SFR_OP_LEN-1:0] OP_TH_WR = OP_TH0_WR_BYTE
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_tick,
    input  logic [3:0]            i_tmod_nib,
    input  logic                  i_tr,
    input  logic                  i_tr_alt,
    input  logic                  i_int_n,
    input  logic                  i_t_pin,
    input  logic [7:0]            i_byte,
    input  logic [SFR_OP_LEN-1:0] i_op,
    output logic [7:0]            o_tl,
    output logic [7:0]            o_th,
    output logic                  o_tf_set,
    output logic                  o_tf_alt
);

    logic [7:0] r_tl;
    logic [7:0] r_th;
    logic       r_tf_set;
    logic       r_tf_alt;

    logic       w_t_fall;
    logic       w_int_sync;
    tmr_mode_e  w_mode;
    logic       w_run;
    logic       w_inc;
    logic       w_wr_tl;
    logic       w_wr_th;
    logic [12:0] w_cnt13;
    logic [15:0] w_cnt16;
    logic [7:0] w_tl_nxt;
    logic [7:0] w_th_nxt;
    logic       w_tf_set_nxt;
    logic       w_tf_alt_nxt;

    timer_pin_sync u_pin_sync (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_tick     (i_tick),
        .i_t_pin    (i_t_pin),
        .i_int_n    (i_int_n),
        .o_t_fall   (w_t_fall),
        .o_int_sync (w_int_sync)
    );

    assign w_mode  = tmr_mode_e'({i_tmod_nib[TMOD_M1], i_tmod_nib[TMOD_M0]});
    assign w_run   = i_tr & (~i_tmod_nib[TMOD_GATE] | w_int_sync);
    assign w_inc   = w_run & (i_tmod_nib[TMOD_CT] ? w_t_fall : i_tick);
    assign w_wr_tl = |(i_op & OP_TL_WR);
    assign w_wr_th = |(i_op & OP_TH_WR);
    assign w_cnt13 = {r_th, r_tl[4:0]} + 13'd1;
    assign w_cnt16 = {r_th, r_tl} + 16'd1;

    // Next count values and overflow pulses; an SFR write pre-empts counting
    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        w_tl_nxt     = r_tl;
        w_th_nxt     = r_th;
        w_tf_set_nxt = 1'b0;
        w_tf_alt_nxt = 1'b0;
        if (w_wr_tl || w_wr_th) begin
            if (w_wr_tl) w_tl_nxt = i_byte;
            if (w_wr_th) w_th_nxt = i_byte;
        end else begin
            case (w_mode)
                MODE_13B: begin
                    if (w_inc) begin
                        w_tl_nxt     = {r_tl[7:5], w_cnt13[4:0]};
                        w_th_nxt     = w_cnt13[12:5];
                        w_tf_set_nxt = &{r_th, r_tl[4:0]};
                    end
                end
                MODE_16B: begin
                    if (w_inc) begin
                        {w_th_nxt, w_tl_nxt} = w_cnt16;
                        w_tf_set_nxt         = &{r_th, r_tl};
                    end
                end
                MODE_AR8: begin
                    if (w_inc) begin
                        if (r_tl == 8'hFF) begin
                            w_tl_nxt     = r_th;
                            w_tf_set_nxt = 1'b1;
                        end else begin
                            w_tl_nxt = r_tl + 8'd1;
                        end
                    end
                end
                MODE_SPLIT: begin
                    // Timer 1 simply holds in mode 3; Timer 0 splits into two 8-bit halves
                    if (IS_T0) begin
                        if (w_inc) begin
                            w_tl_nxt     = r_tl + 8'd1;
                            w_tf_set_nxt = &r_tl;
                        end
                        if (i_tick && i_tr_alt) begin
                            w_th_nxt     = r_th + 8'd1;
                            w_tf_alt_nxt = &r_th;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Count registers and one-cycle overflow pulses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tl     <= 8'h00;
            r_th     <= 8'h00;
            r_tf_set <= 1'b0;
            r_tf_alt <= 1'b0;
        end else begin
            r_tl     <= w_tl_nxt;
            r_th     <= w_th_nxt;
            r_tf_set <= w_tf_set_nxt;
            r_tf_alt <= w_tf_alt_nxt;
        end
    end

    assign o_tl     = r_tl;
    assign o_th     = r_th;
    assign o_tf_set = r_tf_set;
    assign o_tf_alt = r_tf_alt;

endmodule

// File: tb/tb_timer_counter_unit.sv
// Directed bench for timer_counter_unit (Timer 0 instance) with
// hand-computed expected values for each mode and corner case.
module tb_timer_counter_unit;
    import timer_counter_unit_pkg::*;

    logic                  clk;
    logic                  rst_n;
    logic                  i_tick;
    logic [3:0]            i_tmod_nib;
    logic                  i_tr;
    logic                  i_tr_alt;
    logic                  i_int_n;
    logic                  i_t_pin;
    logic [7:0]            i_byte;
    logic [SFR_OP_LEN-1:0] i_op;
    logic [7:0]            o_tl;
    logic [7:0]            o_th;
    logic                  o_tf_set;
    logic                  o_tf_alt;

    int n_checks = 0;
    int n_fails  = 0;
    int n_pulses;

    timer_counter_unit #(
        .IS_T0    (1'b1),
        .OP_TL_WR (OP_TL0_WR_BYTE),
        .OP_TH_WR (OP_TH0_WR_BYTE)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_tick     (i_tick),
        .i_tmod_nib (i_tmod_nib),
        .i_tr       (i_tr),
        .i_tr_alt   (i_tr_alt),
        .i_int_n    (i_int_n),
        .i_t_pin    (i_t_pin),
        .i_byte     (i_byte),
        .i_op       (i_op),
        .o_tl       (o_tl),
        .o_th       (o_th),
        .o_tf_set   (o_tf_set),
        .o_tf_alt   (o_tf_alt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One machine-cycle tick after an idle gap; returns on the negedge after the consuming edge
    task automatic tick_once();
        repeat (10) @(negedge clk);
        i_tick = 1'b1;
        @(negedge clk);
        i_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick_once();
    endtask

    task automatic sfr_wr(input logic [SFR_OP_LEN-1:0] op, input logic [7:0] val);
        @(negedge clk);
        i_op   = op;
        i_byte = val;
        @(negedge clk);
        i_op   = '0;
        i_byte = 8'h00;
    endtask

    initial begin
        rst_n      = 1'b0;
        i_tick     = 1'b0;
        i_tmod_nib = 4'b0000;
        i_tr       = 1'b0;
        i_tr_alt   = 1'b0;
        i_int_n    = 1'b1;
        i_t_pin    = 1'b1;
        i_byte     = 8'h00;
        i_op       = '0;
        repeat (3) @(negedge clk);
        check("rst_tl", {8'h00, o_tl}, 16'h0000);
        check("rst_th", {8'h00, o_th}, 16'h0000);
        check("rst_tf_set", {15'd0, o_tf_set}, 16'd0);
        check("rst_tf_alt", {15'd0, o_tf_alt}, 16'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Mode 1: FFFE -> FFFF -> 0000 with a single-cycle pulse
        i_tmod_nib = 4'b0001;
        sfr_wr(OP_TL0_WR_BYTE, 8'hFE);
        sfr_wr(OP_TH0_WR_BYTE, 8'hFF);
        i_tr = 1'b1;
        tick_once();
        check("m1_cnt1", {o_th, o_tl}, 16'hFFFF);
        check("m1_tf1", {15'd0, o_tf_set}, 16'd0);
        tick_once();
        check("m1_wrap", {o_th, o_tl}, 16'h0000);
        check("m1_tf_wrap", {15'd0, o_tf_set}, 16'd1);
        @(negedge clk);
        check("m1_tf_after", {15'd0, o_tf_set}, 16'd0);

        // Mode 0: 13-bit wrap keeps TL[7:5]
        i_tr       = 1'b0;
        i_tmod_nib = 4'b0000;
        sfr_wr(OP_TH0_WR_BYTE, 8'hFF);
        sfr_wr(OP_TL0_WR_BYTE, 8'hFF);
        i_tr = 1'b1;
        tick_once();
        check("m0_wrap", {o_th, o_tl}, 16'h00E0);
        check("m0_tf", {15'd0, o_tf_set}, 16'd1);

        // Mode 2: reload from TH, then a second overflow after 100 ticks
        i_tr       = 1'b0;
        i_tmod_nib = 4'b0010;
        sfr_wr(OP_TH0_WR_BYTE, 8'h9C);
        sfr_wr(OP_TL0_WR_BYTE, 8'hFF);
        i_tr = 1'b1;
        tick_once();
        check("m2_reload", {o_th, o_tl}, 16'h9C9C);
        check("m2_tf", {15'd0, o_tf_set}, 16'd1);
        n_pulses = 0;
        for (int k = 0; k < 100; k++) begin
            tick_once();
            if (o_tf_set) n_pulses++;
            if (k == 98) check("m2_tl_ff", {8'h00, o_tl}, 16'h00FF);
        end
        check("m2_pulses", n_pulses[15:0], 16'd1);
        check("m2_after100", {o_th, o_tl}, 16'h9C9C);

        // Gated timer: counts only while INTx is high
        i_tr       = 1'b0;
        i_tmod_nib = 4'b1001;
        sfr_wr(OP_TL0_WR_BYTE, 8'h00);
        sfr_wr(OP_TH0_WR_BYTE, 8'h00);
        i_int_n = 1'b0;
        repeat (3) @(negedge clk);
        i_tr = 1'b1;
        ticks(5);
        check("gate_low", {o_th, o_tl}, 16'h0000);
        i_int_n = 1'b1;
        repeat (3) @(negedge clk);
        ticks(5);
        check("gate_high", {o_th, o_tl}, 16'h0005);

        // Counter mode: three clean falling edges, then a short glitch
        i_tr       = 1'b0;
        i_tmod_nib = 4'b0101;
        sfr_wr(OP_TL0_WR_BYTE, 8'h00);
        sfr_wr(OP_TH0_WR_BYTE, 8'h00);
        i_tr = 1'b1;
        ticks(2);
        for (int k = 0; k < 3; k++) begin
            i_t_pin = 1'b0;
            ticks(2);
            i_t_pin = 1'b1;
            ticks(2);
        end
        check("ctr_3edges", {o_th, o_tl}, 16'h0003);
        repeat (2) @(negedge clk);
        i_t_pin = 1'b0;
        @(negedge clk);
        i_t_pin = 1'b1;
        ticks(3);
        check("ctr_glitch", {o_th, o_tl}, 16'h0003);

        // Timer 0 mode 3: TH runs from TR1 and overflows into TF1
        i_tr       = 1'b0;
        i_tmod_nib = 4'b0011;
        sfr_wr(OP_TL0_WR_BYTE, 8'h00);
        sfr_wr(OP_TH0_WR_BYTE, 8'hFF);
        i_tr_alt = 1'b1;
        tick_once();
        check("m3_th_wrap", {o_th, o_tl}, 16'h0000);
        check("m3_tf_alt", {15'd0, o_tf_alt}, 16'd1);
        check("m3_tf_set0", {15'd0, o_tf_set}, 16'd0);
        @(negedge clk);
        check("m3_tf_alt_after", {15'd0, o_tf_alt}, 16'd0);

        // A TH write on a tick blocks both halves, even a pending TL wrap
        sfr_wr(OP_TL0_WR_BYTE, 8'hFF);
        i_tr = 1'b1;
        repeat (10) @(negedge clk);
        i_tick = 1'b1;
        i_op   = OP_TH0_WR_BYTE;
        i_byte = 8'h55;
        @(negedge clk);
        i_tick = 1'b0;
        i_op   = '0;
        i_byte = 8'h00;
        check("wr_tick_val", {o_th, o_tl}, 16'h55FF);
        check("wr_tick_tf", {14'd0, o_tf_alt, o_tf_set}, 16'd0);
        tick_once();
        check("m3_tl_wrap", {o_th, o_tl}, 16'h5600);
        check("m3_tl_tf", {14'd0, o_tf_alt, o_tf_set}, 16'd1);

        // Reset while a pulse is high and the count is non-zero
        i_tr       = 1'b0;
        i_tr_alt   = 1'b0;
        i_tmod_nib = 4'b0010;
        sfr_wr(OP_TH0_WR_BYTE, 8'h9C);
        sfr_wr(OP_TL0_WR_BYTE, 8'hFF);
        i_tr = 1'b1;
        tick_once();
        check("pre_rst_val", {o_th, o_tl}, 16'h9C9C);
        check("pre_rst_tf", {15'd0, o_tf_set}, 16'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_cnt", {o_th, o_tl}, 16'h0000);
        check("mid_rst_tf", {14'd0, o_tf_alt, o_tf_set}, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
